// File: rtl/ibex_xif_trace_pkg.sv
// ibex_xif_trace_pkg: trace record type and the RVFI channel packing helper.
// Contents:
//   trace_rec_t       packed retire record; bit order gap..rd_wdata, 168 bits total.
//   TraceMaxChannels  largest supported number of retire channels.
//   pack_rec()        builds one trace_rec_t from a single RVFI channel.
package ibex_xif_trace_pkg;

    localparam int unsigned TraceMaxChannels = 4;

    typedef struct packed {
        logic        gap;
        logic        trap;
        logic        intr;
        logic [4:0]  rd_addr;
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] rd_wdata;
    } trace_rec_t;

    function automatic trace_rec_t pack_rec(
        input logic        gap,
        input logic        trap,
        input logic        intr,
        input logic [4:0]  rd_addr,
        input logic [63:0] order,
        input logic [31:0] insn,
        input logic [31:0] pc,
        input logic [31:0] rd_wdata
    );
        trace_rec_t r;
        r.gap      = gap;
        r.trap     = trap;
        r.intr     = intr;
        r.rd_addr  = rd_addr;
        r.order    = order;
        r.insn     = insn;
        r.pc       = pc;
        r.rd_wdata = rd_wdata;
        return r;
    endfunction

endpackage

// File: rtl/ibex_xif_trace_fifo_mw.sv
// ibex_xif_trace_fifo_mw: multi-write, single-read first-word-fall-through record FIFO.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         synchronous clear of pointers and fill; blocks push and pop that cycle
//   push_cnt_i      number of compacted records in wdata_i[0..push_cnt_i-1] to write
//   wdata_i         compacted write records, slot 0 is oldest
//   pop_i           remove the head record (caller guarantees fill != 0)
//   rdata_o         head record, '0 when empty
//   fill_o          occupied entries
//   space_o         free entries this cycle, counting a slot freed by a same-cycle pop
module ibex_xif_trace_fifo_mw
    import ibex_xif_trace_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned Depth       = 16,
    localparam int unsigned PtrW       = $clog2(Depth),
    localparam int unsigned CntW       = PtrW + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [CntW-1:0]              push_cnt_i,
    input  trace_rec_t [NumChannels-1:0] wdata_i,
    input  logic                         pop_i,
    output trace_rec_t                   rdata_o,
    output logic [CntW-1:0]              fill_o,
    output logic [CntW-1:0]              space_o
);

    trace_rec_t      mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] fill;

    assign fill_o  = fill;
    assign space_o = CntW'(Depth) - fill + CntW'(pop_i);
    assign rdata_o = (fill != '0) ? mem[rptr] : '0;

    // Storage needs no reset: only slots between rptr and wptr are ever observed.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumChannels; i++) begin
            if (!flush_i && CntW'(i) < push_cnt_i) mem[wptr + PtrW'(i)] <= wdata_i[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else begin
            wptr <= wptr + PtrW'(push_cnt_i);
            rptr <= rptr + PtrW'(pop_i);
            fill <= fill + push_cnt_i - CntW'(pop_i);
        end
    end

endmodule

// File: rtl/ibex_xif_rvfi_trace_buffer.sv
// ibex_xif_rvfi_trace_buffer: multi-channel RVFI retire-record buffer feeding a tracer.
// Optional feature macro: IBEX_XIF_TRACE_FILTER_EN adds a PC window filter.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_i               synchronous clear of all state; inputs that cycle are discarded
//   rvfi_*_i              per-channel retire data, channel k in slice k
//   trace_valid_o         head record valid
//   trace_ready_i         sink accepts head record
//   trace_rec_o           head record, '0 when empty
//   fill_o                occupied FIFO entries
//   drop_cnt_o            saturating count of dropped records
//   order_err_o           sticky rvfi_order discontinuity flag
//   filter_lo_i/hi_i      inclusive PC window (only with IBEX_XIF_TRACE_FILTER_EN)
module ibex_xif_rvfi_trace_buffer
    import ibex_xif_trace_pkg::*;
#(
    parameter int unsigned NumChannels  = 2,
    parameter int unsigned Depth        = 16,
    parameter int unsigned DropCntWidth = 16,
    localparam int unsigned CntW        = $clog2(Depth) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [NumChannels-1:0]    rvfi_valid_i,
    input  logic [NumChannels*64-1:0] rvfi_order_i,
    input  logic [NumChannels*32-1:0] rvfi_insn_i,
    input  logic [NumChannels*32-1:0] rvfi_pc_rdata_i,
    input  logic [NumChannels*5-1:0]  rvfi_rd_addr_i,
    input  logic [NumChannels*32-1:0] rvfi_rd_wdata_i,
    input  logic [NumChannels-1:0]    rvfi_trap_i,
    input  logic [NumChannels-1:0]    rvfi_intr_i,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output trace_rec_t                trace_rec_o,
    output logic [CntW-1:0]           fill_o,
    output logic [DropCntWidth-1:0]   drop_cnt_o,
    output logic                      order_err_o
`ifdef IBEX_XIF_TRACE_FILTER_EN
    ,
    input  logic [31:0]               filter_lo_i,
    input  logic [31:0]               filter_hi_i
`endif
);

    logic [NumChannels-1:0]       accept;
    logic [CntW-1:0]              pos [NumChannels];
    trace_rec_t [NumChannels-1:0] wdata;
    logic [CntW-1:0]              group_n;
    logic [CntW-1:0]              space;
    logic [CntW-1:0]              push_cnt;
    logic [CntW-1:0]              fill;
    logic                         pop;
    logic                         push;
    logic                         drop;
    logic                         pending_gap;
    logic [DropCntWidth-1:0]      drop_cnt;
    logic [DropCntWidth:0]        drop_sum;
    logic [63:0]                  exp_order;
    logic [63:0]                  base_order;
    logic [63:0]                  last_order;
    logic [2:0]                   vcnt;
    logic                         seen;
    logic                         order_init;
    logic                         order_err;
    logic                         order_mis;

`ifdef IBEX_XIF_TRACE_FILTER_EN
    for (genvar g = 0; g < NumChannels; g++) begin : g_filt
        assign accept[g] = rvfi_valid_i[g] &&
                           rvfi_pc_rdata_i[g*32 +: 32] >= filter_lo_i &&
                           rvfi_pc_rdata_i[g*32 +: 32] <= filter_hi_i;
    end
`else
    assign accept = rvfi_valid_i;
`endif

    // Each accepted channel lands in the slot given by the number of accepted channels below it.
    always_comb begin
        group_n = '0;
        for (int k = 0; k < NumChannels; k++) begin
            pos[k]  = group_n;
            group_n = group_n + CntW'(accept[k]);
        end
    end

    always_comb begin
        wdata = '0;
        for (int j = 0; j < NumChannels; j++) begin
            for (int k = 0; k < NumChannels; k++) begin
                if (accept[k] && pos[k] == CntW'(j)) begin
                    wdata[j] = pack_rec(1'b0, rvfi_trap_i[k], rvfi_intr_i[k],
                                        rvfi_rd_addr_i[k*5 +: 5], rvfi_order_i[k*64 +: 64],
                                        rvfi_insn_i[k*32 +: 32], rvfi_pc_rdata_i[k*32 +: 32],
                                        rvfi_rd_wdata_i[k*32 +: 32]);
                end
            end
        end
        wdata[0].gap = pending_gap;
    end

    assign pop      = trace_valid_o & trace_ready_i;
    assign push     = group_n != '0 && group_n <= space;
    assign drop     = group_n != '0 && group_n > space;
    assign push_cnt = push ? group_n : '0;
    assign drop_sum = {1'b0, drop_cnt} + (DropCntWidth + 1)'(group_n);

    // Order check sees every valid record, including filtered and dropped ones.
    always_comb begin
        base_order = exp_order;
        last_order = exp_order;
        seen       = order_init;
        order_mis  = 1'b0;
        vcnt       = '0;
        for (int k = 0; k < NumChannels; k++) begin
            if (rvfi_valid_i[k]) begin
                if (!seen) base_order = rvfi_order_i[k*64 +: 64];
                seen = 1'b1;
                if (rvfi_order_i[k*64 +: 64] != base_order + 64'(vcnt)) order_mis = 1'b1;
                last_order = rvfi_order_i[k*64 +: 64];
                vcnt       = vcnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_gap <= 1'b0;
            drop_cnt    <= '0;
            order_err   <= 1'b0;
            order_init  <= 1'b0;
            exp_order   <= '0;
        end else if (flush_i) begin
            pending_gap <= 1'b0;
            drop_cnt    <= '0;
            order_err   <= 1'b0;
            order_init  <= 1'b0;
            exp_order   <= '0;
        end else begin
            if (drop) begin
                pending_gap <= 1'b1;
                drop_cnt    <= drop_sum[DropCntWidth] ? '1 : drop_sum[DropCntWidth-1:0];
            end else if (push) begin
                pending_gap <= 1'b0;
            end
            if (|rvfi_valid_i) begin
                order_init <= 1'b1;
                exp_order  <= last_order + 64'd1;
                if (order_mis) order_err <= 1'b1;
            end
        end
    end

    ibex_xif_trace_fifo_mw #(
        .NumChannels (NumChannels),
        .Depth       (Depth)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .push_cnt_i (push_cnt),
        .wdata_i    (wdata),
        .pop_i      (pop),
        .rdata_o    (trace_rec_o),
        .fill_o     (fill),
        .space_o    (space)
    );

    assign trace_valid_o = fill != '0;
    assign fill_o        = fill;
    assign drop_cnt_o    = drop_cnt;
    assign order_err_o   = order_err;

endmodule

// File: tb/tb_ibex_xif_rvfi_trace_buffer.sv
// tb_ibex_xif_rvfi_trace_buffer: directed self-checking bench, 2 channels, depth 4.
module tb_ibex_xif_rvfi_trace_buffer;
    import ibex_xif_trace_pkg::*;

    localparam int NC = 2;
    localparam int D  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            ready = 1'b0;
    logic [NC-1:0]   valid;
    logic [NC*64-1:0] order;
    logic [NC*32-1:0] insn;
    logic [NC*32-1:0] pc;
    logic [NC*5-1:0]  rd;
    logic [NC*32-1:0] wd;
    logic [NC-1:0]   trap;
    logic [NC-1:0]   intr;
    logic            tvalid;
    trace_rec_t      rec;
    logic [2:0]      fill;
    logic [DW-1:0]   drop;
    logic            oerr;
`ifdef IBEX_XIF_TRACE_FILTER_EN
    logic [31:0]     flo = 32'h0;
    logic [31:0]     fhi = 32'hFFFF_FFFF;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ibex_xif_rvfi_trace_buffer #(.NumChannels(NC), .Depth(D), .DropCntWidth(DW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .rvfi_valid_i    (valid),
        .rvfi_order_i    (order),
        .rvfi_insn_i     (insn),
        .rvfi_pc_rdata_i (pc),
        .rvfi_rd_addr_i  (rd),
        .rvfi_rd_wdata_i (wd),
        .rvfi_trap_i     (trap),
        .rvfi_intr_i     (intr),
        .trace_valid_o   (tvalid),
        .trace_ready_i   (ready),
        .trace_rec_o     (rec),
        .fill_o          (fill),
        .drop_cnt_o      (drop),
        .order_err_o     (oerr)
`ifdef IBEX_XIF_TRACE_FILTER_EN
        ,
        .filter_lo_i     (flo),
        .filter_hi_i     (fhi)
`endif
    );

    function automatic logic [31:0] pcof(input logic [63:0] o);
        return 32'h1000 + o[31:0] * 4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        valid = '0; order = '0; insn = '0; pc = '0; rd = '0; wd = '0; trap = '0; intr = '0;
    endtask

    task automatic set_chp(input int k, input logic [63:0] o, input logic [31:0] p);
        valid[k]         = 1'b1;
        order[k*64 +: 64] = o;
        pc[k*32 +: 32]    = p;
        insn[k*32 +: 32]  = 32'h13 + o[31:0];
        rd[k*5 +: 5]      = o[4:0];
        wd[k*32 +: 32]    = ~o[31:0];
    endtask

    task automatic set_ch(input int k, input logic [63:0] o);
        set_chp(k, o, pcof(o));
    endtask

    task automatic do_flush();
        clr();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        clr();
        #2;
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", tvalid); end
        checks++; if (fill !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
        checks++; if (drop !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop); end
        checks++; if (oerr !== 1'b0) begin failures++; $display("FAIL reset_oerr got=%0b exp=0", oerr); end
        checks++; if (rec !== '0) begin failures++; $display("FAIL reset_rec got=%0h exp=0", rec); end
        #10;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_flush();
        ready = 1'b1;
        clr(); set_ch(0, 10); set_ch(1, 11);
        step();
        checks++; if (rec.order !== 64'd10) begin failures++; $display("FAIL basic_head10 got=%0d exp=10", rec.order); end
        checks++; if (fill !== 3'd2) begin failures++; $display("FAIL basic_fill2 got=%0d exp=2", fill); end
        clr(); set_ch(0, 12);
        step();
        checks++; if (rec.order !== 64'd11) begin failures++; $display("FAIL basic_head11 got=%0d exp=11", rec.order); end
        clr();
        step();
        checks++; if (rec.order !== 64'd12 || rec.pc !== 32'h1030) begin failures++; $display("FAIL basic_head12 got=%0d/%0h exp=12/1030", rec.order, rec.pc); end
        step();
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL basic_empty got=%0b exp=0", tvalid); end
        checks++; if (oerr !== 1'b0 || drop !== 16'd0) begin failures++; $display("FAIL basic_status got=%0b/%0d exp=0/0", oerr, drop); end
    endtask

    task automatic test_drop_gap();
        do_flush();
        ready = 1'b0;
        clr(); set_ch(0, 0); set_ch(1, 1);
        step();
        clr(); set_ch(0, 2); set_ch(1, 3);
        step();
        checks++; if (fill !== 3'd4) begin failures++; $display("FAIL drop_fill4 got=%0d exp=4", fill); end
        clr(); set_ch(0, 4); set_ch(1, 5);
        step();
        checks++; if (drop !== 16'd2) begin failures++; $display("FAIL drop_cnt got=%0d exp=2", drop); end
        checks++; if (fill !== 3'd4 || rec.order !== 64'd0) begin failures++; $display("FAIL drop_hold got=%0d/%0d exp=4/0", fill, rec.order); end
        clr(); ready = 1'b1; set_ch(0, 6);
        step();
        checks++; if (rec.order !== 64'd1 || fill !== 3'd4) begin failures++; $display("FAIL drop_head1 got=%0d/%0d exp=1/4", rec.order, fill); end
        clr();
        step();
        step();
        checks++; if (rec.order !== 64'd3 || rec.gap !== 1'b0) begin failures++; $display("FAIL drop_head3 got=%0d/%0b exp=3/0", rec.order, rec.gap); end
        step();
        checks++; if (rec.order !== 64'd6 || rec.gap !== 1'b1) begin failures++; $display("FAIL drop_gap6 got=%0d/%0b exp=6/1", rec.order, rec.gap); end
        step();
        checks++; if (fill !== 3'd0 || drop !== 16'd2) begin failures++; $display("FAIL drop_drain got=%0d/%0d exp=0/2", fill, drop); end
    endtask

    task automatic test_full_pop_push();
        do_flush();
        ready = 1'b0;
        clr(); set_ch(0, 0); set_ch(1, 1);
        step();
        clr(); set_ch(0, 2); set_ch(1, 3);
        step();
        ready = 1'b1;
        clr(); set_ch(0, 4);
        step();
        checks++; if (fill !== 3'd4) begin failures++; $display("FAIL full_fill got=%0d exp=4", fill); end
        checks++; if (drop !== 16'd0) begin failures++; $display("FAIL full_drop got=%0d exp=0", drop); end
        checks++; if (rec.order !== 64'd1) begin failures++; $display("FAIL full_head got=%0d exp=1", rec.order); end
        clr();
        step(); step(); step();
        checks++; if (rec.order !== 64'd4 || rec.gap !== 1'b0) begin failures++; $display("FAIL full_last got=%0d/%0b exp=4/0", rec.order, rec.gap); end
    endtask

    task automatic test_order_err();
        do_flush();
        ready = 1'b1;
        clr(); set_ch(0, 20); set_ch(1, 21);
        step();
        checks++; if (oerr !== 1'b0) begin failures++; $display("FAIL order_ok got=%0b exp=0", oerr); end
        clr(); set_ch(0, 23);
        step();
        checks++; if (oerr !== 1'b1) begin failures++; $display("FAIL order_err got=%0b exp=1", oerr); end
        clr(); set_ch(0, 24);
        step();
        checks++; if (oerr !== 1'b1) begin failures++; $display("FAIL order_sticky got=%0b exp=1", oerr); end
        clr(); set_ch(0, 99); flush = 1'b1;
        step();
        flush = 1'b0; clr();
        checks++; if (oerr !== 1'b0 || fill !== 3'd0) begin failures++; $display("FAIL order_flush got=%0b/%0d exp=0/0", oerr, fill); end
        set_ch(0, 50);
        step();
        clr();
        checks++; if (oerr !== 1'b0 || rec.order !== 64'd50) begin failures++; $display("FAIL order_reinit got=%0b/%0d exp=0/50", oerr, rec.order); end
    endtask

    task automatic test_sparse();
        do_flush();
        ready = 1'b0;
        clr(); set_ch(1, 7);
        step();
        clr();
        checks++; if (fill !== 3'd1) begin failures++; $display("FAIL sparse_fill got=%0d exp=1", fill); end
        checks++; if (rec.order !== 64'd7 || rec.pc !== 32'h101C || rec.rd_addr !== 5'd7) begin failures++; $display("FAIL sparse_rec got=%0d/%0h/%0d exp=7/101c/7", rec.order, rec.pc, rec.rd_addr); end
    endtask

`ifdef IBEX_XIF_TRACE_FILTER_EN
    task automatic test_filter();
        do_flush();
        flo = 32'h100; fhi = 32'h1FF;
        ready = 1'b0;
        clr(); set_chp(0, 0, 32'h0FC); set_chp(1, 1, 32'h100);
        step();
        clr(); set_chp(0, 2, 32'h1FF); set_chp(1, 3, 32'h200);
        step();
        clr();
        checks++; if (fill !== 3'd2 || drop !== 16'd0) begin failures++; $display("FAIL filt_fill got=%0d/%0d exp=2/0", fill, drop); end
        checks++; if (rec.pc !== 32'h100 || rec.gap !== 1'b0) begin failures++; $display("FAIL filt_first got=%0h/%0b exp=100/0", rec.pc, rec.gap); end
        ready = 1'b1;
        step();
        checks++; if (rec.pc !== 32'h1FF || rec.gap !== 1'b0) begin failures++; $display("FAIL filt_second got=%0h/%0b exp=1ff/0", rec.pc, rec.gap); end
        step();
        checks++; if (fill !== 3'd0 || oerr !== 1'b0) begin failures++; $display("FAIL filt_end got=%0d/%0b exp=0/0", fill, oerr); end
        flo = 32'h0; fhi = 32'hFFFF_FFFF;
    endtask
`endif

    task automatic test_mid_reset();
        do_flush();
        ready = 1'b0;
        clr(); set_ch(0, 0);
        step();
        clr(); set_ch(0, 1); set_ch(1, 2);
        step();
        clr(); set_ch(0, 3); set_ch(1, 4);
        step();
        clr();
        checks++; if (fill !== 3'd3 || drop !== 16'd2) begin failures++; $display("FAIL mrst_pre got=%0d/%0d exp=3/2", fill, drop); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tvalid !== 1'b0 || fill !== 3'd0) begin failures++; $display("FAIL mrst_clear got=%0b/%0d exp=0/0", tvalid, fill); end
        checks++; if (drop !== 16'd0 || rec !== '0) begin failures++; $display("FAIL mrst_drop got=%0d/%0h exp=0/0", drop, rec); end
        #1 rst_n = 1'b1;
        set_ch(0, 0);
        step();
        clr();
        checks++; if (rec.order !== 64'd0 || rec.gap !== 1'b0 || fill !== 3'd1) begin failures++; $display("FAIL mrst_after got=%0d/%0b/%0d exp=0/0/1", rec.order, rec.gap, fill); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop_gap();
        test_full_pop_push();
        test_order_err();
        test_sparse();
`ifdef IBEX_XIF_TRACE_FILTER_EN
        test_filter();
`endif
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
